// File: rtl/multicycle_cpu.sv
// Multi-cycle RV32I core: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with IR/A/B/ALUOut/MDR latches.
// Instruction ROM is read straight from the input array; register file and data RAM preload on reset.
module multicycle_cpu #(
  parameter int unsigned IMEM_DEPTH = 32,
  parameter int unsigned DMEM_DEPTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] initial_instructions    [0:IMEM_DEPTH-1],
  input  logic [31:0] initial_register_values [0:31],
  input  logic [31:0] initial_memory_values   [0:DMEM_DEPTH-1],
  output logic        halted,
  output logic [2:0]  state_check,
  output logic [31:0] pc_check,
  output logic [31:0] retired_count,
  output logic [31:0] register_check [0:31],
  output logic [31:0] memory_check   [0:DMEM_DEPTH-1]
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] regs_q [0:31];
  logic [31:0] regs_d [0:31];
  logic [31:0] mem_q  [0:DMEM_DEPTH-1];
  logic [31:0] mem_d  [0:DMEM_DEPTH-1];

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, pc_plus4;
  logic [IAW-1:0] i_idx;
  logic [DAW-1:0] d_idx;
  logic        legal, br_taken, alu_alt;
  logic [31:0] alu_b, alu_res, wb_data;
  logic signed [31:0] sra_res;

  // IR is stable from DECODE onward, so field/immediate decode is purely combinational.
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u  = {ir_q[31:12], 12'd0};
  assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
  assign pc_plus4 = pc_q + 32'd4;
  // Upper address bits are dropped so both memories wrap modulo their depth.
  assign i_idx    = pc_q[IAW+1:2];
  assign d_idx    = alu_out_q[DAW+1:2];

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R: legal = (funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      OP_I: begin
        if (funct3 == 3'b001)      legal = (funct7 == 7'h00);
        else if (funct3 == 3'b101) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        else                       legal = 1'b1;
      end
      OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
      OP_JALR:       legal = (funct3 == 3'b000);
      OP_LW, OP_SW:  legal = (funct3 == 3'b010);
      OP_BR:         legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      default:       legal = 1'b0;
    endcase
  end

  // funct7[5] means SUB only for R-type; for I-type it only matters on the right shifts.
  assign alu_b   = (opcode == OP_R) ? b_q : imm_i;
  assign alu_alt = funct7[5] && ((opcode == OP_R) || (funct3 == 3'b101));
  assign sra_res = $signed(a_q) >>> alu_b[4:0];

  always_comb begin
    alu_res = 32'd0;
    case (funct3)
      3'b000: alu_res = alu_alt ? (a_q - alu_b) : (a_q + alu_b);
      3'b001: alu_res = a_q << alu_b[4:0];
      3'b010: alu_res = {31'd0, $signed(a_q) < $signed(alu_b)};
      3'b011: alu_res = {31'd0, a_q < alu_b};
      3'b100: alu_res = a_q ^ alu_b;
      3'b101: alu_res = alu_alt ? sra_res : (a_q >> alu_b[4:0]);
      3'b110: alu_res = a_q | alu_b;
      3'b111: alu_res = a_q & alu_b;
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000: br_taken = (a_q == b_q);
      3'b001: br_taken = (a_q != b_q);
      3'b100: br_taken = ($signed(a_q) <  $signed(b_q));
      3'b101: br_taken = ($signed(a_q) >= $signed(b_q));
      3'b110: br_taken = (a_q <  b_q);
      3'b111: br_taken = (a_q >= b_q);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    wb_data = alu_out_q;
    if (opcode == OP_LW)                           wb_data = mdr_q;
    else if ((opcode == OP_JAL) || (opcode == OP_JALR)) wb_data = pc_plus4;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    retired_d = retired_q;
    regs_d    = regs_q;
    mem_d     = mem_q;
    case (state_q)
      S_FETCH: begin
        ir_d    = initial_instructions[i_idx];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = rs1_val;
        b_d     = rs2_val;
        state_d = legal ? S_EXECUTE : S_HALT;
      end
      S_EXECUTE: begin
        state_d = S_WRITEBACK;
        case (opcode)
          OP_BR: begin
            alu_out_d = pc_q + imm_b;
            pc_d      = br_taken ? (pc_q + imm_b) : pc_plus4;
            retired_d = retired_q + 32'd1;
            state_d   = S_FETCH;
          end
          OP_LW: begin
            alu_out_d = a_q + imm_i;
            state_d   = S_MEMORY;
          end
          OP_SW: begin
            alu_out_d = a_q + imm_s;
            state_d   = S_MEMORY;
          end
          OP_LUI:   alu_out_d = imm_u;
          OP_AUIPC: alu_out_d = pc_q + imm_u;
          // Jumps park the target in ALUOut; WRITEBACK links pc+4 and redirects.
          OP_JAL:   alu_out_d = pc_q + imm_j;
          OP_JALR:  alu_out_d = (a_q + imm_i) & 32'hFFFF_FFFE;
          default:  alu_out_d = alu_res;
        endcase
      end
      S_MEMORY: begin
        if (opcode == OP_SW) begin
          mem_d[d_idx] = b_q;
          pc_d         = pc_plus4;
          retired_d    = retired_q + 32'd1;
          state_d      = S_FETCH;
        end else begin
          mdr_d   = mem_q[d_idx];
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        if (rd != 5'd0) regs_d[rd] = wb_data;
        pc_d      = ((opcode == OP_JAL) || (opcode == OP_JALR)) ? alu_out_q : pc_plus4;
        retired_d = retired_q + 32'd1;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      alu_out_q <= 32'd0;
      mdr_q     <= 32'd0;
      retired_q <= 32'd0;
      for (int i = 0; i < 32; i++)
        regs_q[i] <= (i == 0) ? 32'd0 : initial_register_values[i];
      for (int j = 0; j < DMEM_DEPTH; j++)
        mem_q[j] <= initial_memory_values[j];
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      retired_q <= retired_d;
      for (int i = 0; i < 32; i++)
        regs_q[i] <= regs_d[i];
      for (int j = 0; j < DMEM_DEPTH; j++)
        mem_q[j] <= mem_d[j];
    end
  end

  assign halted         = (state_q == S_HALT);
  assign state_check    = state_q;
  assign pc_check       = pc_q;
  assign retired_count  = retired_q;
  assign register_check = regs_q;
  assign memory_check   = mem_q;
endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: directed programs plus random forward-only programs,
// checked against an instruction-level RV32I interpreter with per-class cycle costs.
module tb_multicycle_cpu;
  localparam int ID = 32, DD = 32, ID8 = 8;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] imem [0:ID-1];
  logic [31:0] imem8 [0:ID8-1];
  logic [31:0] rinit [0:31];
  logic [31:0] minit [0:DD-1];

  logic        halted_a, halted_b;
  logic [2:0]  st_a, st_b;
  logic [31:0] pc_a, pc_b, ret_a, ret_b;
  logic [31:0] regs_a [0:31];
  logic [31:0] regs_b [0:31];
  logic [31:0] mem_a [0:DD-1];
  logic [31:0] mem_b [0:DD-1];

  multicycle_cpu #(.IMEM_DEPTH(ID), .DMEM_DEPTH(DD), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .initial_instructions(imem),
    .initial_register_values(rinit), .initial_memory_values(minit),
    .halted(halted_a), .state_check(st_a), .pc_check(pc_a), .retired_count(ret_a),
    .register_check(regs_a), .memory_check(mem_a));

  multicycle_cpu #(.IMEM_DEPTH(ID8), .DMEM_DEPTH(DD), .RESET_PC(32'h0)) dut8 (
    .clk(clk), .reset(reset), .initial_instructions(imem8),
    .initial_register_values(rinit), .initial_memory_values(minit),
    .halted(halted_b), .state_check(st_b), .pc_check(pc_b), .retired_count(ret_b),
    .register_check(regs_b), .memory_check(mem_b));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit sel = 1'b0;

  // reference model state
  logic [31:0] prog_m [0:ID-1];
  int          idepth_m = ID;
  logic [31:0] mregs [0:31];
  logic [31:0] mmem [0:DD-1];
  logic [31:0] mpc, mret;
  int          mcyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction

  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    logic [31:0] t;
    t = v << (32 - bits);
    return $signed(t) >>> (32 - bits);
  endfunction

  // Instruction-level interpreter; cycle cost per class: branch 3, SW 4, LW 5, others 4, halt 2.
  task automatic model_run();
    logic [31:0] ins, a, b, immi, imms, immb, immj, res, nxt;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    int          rd, c, idx;
    bit          wr, ill, done, t;
    for (int i = 0; i < 32; i++) mregs[i] = (i == 0) ? 32'd0 : rinit[i];
    mmem = minit;
    mpc = 32'h0; mret = 0; mcyc = 0; done = 0;
    for (int step = 0; step < 2000 && !done; step++) begin
      ins  = prog_m[(mpc >> 2) % idepth_m];
      op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; rd = int'(ins[11:7]);
      a = mregs[ins[19:15]]; b = mregs[ins[24:20]];
      immi = sx(ins >> 20, 12);
      imms = sx({20'd0, ins[31:25], ins[11:7]}, 12);
      immb = sx({19'd0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
      immj = sx({11'd0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
      nxt = mpc + 4; res = 0; wr = 0; ill = 0; c = 4;
      case (op)
        7'h33, 7'h13: begin
          wr = 1;
          if (op == 7'h13) b = immi;
          if (op == 7'h33 && f7 == 7'h20 && f3 == 0) res = a - b;
          else if (f3 == 5 && f7 == 7'h20) res = $signed(a) >>> b[4:0];
          else if (op == 7'h33 && f7 != 0) ill = 1;
          else if (op == 7'h13 && (f3 == 1 || f3 == 5) && f7 != 0) ill = 1;
          else case (f3)
            0: res = a + b;
            1: res = a << b[4:0];
            2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3: res = (a < b) ? 32'd1 : 32'd0;
            4: res = a ^ b;
            5: res = a >> b[4:0];
            6: res = a | b;
            default: res = a & b;
          endcase
        end
        7'h37: begin wr = 1; res = {ins[31:12], 12'd0}; end
        7'h17: begin wr = 1; res = mpc + {ins[31:12], 12'd0}; end
        7'h6F: begin wr = 1; res = mpc + 4; nxt = mpc + immj; end
        7'h67: begin wr = 1; res = mpc + 4; nxt = (a + immi) & 32'hFFFF_FFFE; ill = (f3 != 0); end
        7'h03: begin
          wr = 1; c = 5; ill = (f3 != 2);
          idx = int'(((a + immi) >> 2) % DD);
          res = mmem[idx];
        end
        7'h23: begin
          ill = (f3 != 2);
          idx = int'(((a + imms) >> 2) % DD);
          if (!ill) mmem[idx] = b;
        end
        7'h63: begin
          c = 3; t = 0;
          case (f3)
            0: t = (a == b);
            1: t = (a != b);
            4: t = ($signed(a) < $signed(b));
            5: t = ($signed(a) >= $signed(b));
            6: t = (a < b);
            7: t = (a >= b);
            default: ill = 1;
          endcase
          if (t) nxt = mpc + immb;
        end
        default: ill = 1;
      endcase
      if (ill) begin
        mcyc += 2; done = 1;
      end else begin
        if (wr && rd != 0) mregs[rd] = res;
        mpc = nxt; mret++; mcyc += c;
      end
    end
  endtask

  function automatic logic [31:0] rand_ins();
    int k = $urandom_range(0, 9);
    int rd = $urandom_range(0, 15), r1 = $urandom_range(0, 15), r2 = $urandom_range(0, 15);
    int f3 = $urandom_range(0, 7), imm = $urandom_range(0, 4095);
    case (k)
      0, 1: return enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 'h20 : 0, r2, r1, f3, rd);
      2, 3: begin
        if (f3 == 1) imm = imm & 31;
        else if (f3 == 5) imm = (imm & 31) | (($urandom_range(0, 1) == 1) ? 'h400 : 0);
        return enc_i(imm, r1, f3, rd, 'h13);
      end
      4: return enc_u(int'($urandom), rd, ($urandom_range(0, 1) == 1) ? 'h37 : 'h17);
      5: return enc_i(imm, r1, 2, rd, 'h03);
      6: return enc_s(imm, r2, r1);
      7: begin
        if (f3 == 2 || f3 == 3) f3 += 4;
        return enc_b($urandom_range(2, 3) * 4, r2, r1, f3);
      end
      8: return enc_j(8, rd);
      default: return ($urandom_range(0, 5) == 0) ? enc_r(1, r2, r1, f3, rd) : enc_i(imm, r1, 2, rd, 'h13);
    endcase
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < ID; i++) imem[i] = ECALL;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_to_halt(output int cyc);
    cyc = 0;
    while (!(sel ? halted_b : halted_a) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("halt_reached", {31'd0, sel ? halted_b : halted_a}, 32'd1);
  endtask

  task automatic check_all(input string tag, input int cyc);
    chk({tag, ".pc"}, sel ? pc_b : pc_a, mpc);
    chk({tag, ".retired"}, sel ? ret_b : ret_a, mret);
    chk({tag, ".cycles"}, cyc, mcyc);
    chk({tag, ".state"}, {29'd0, sel ? st_b : st_a}, 32'd5);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s.x%0d", tag, i), sel ? regs_b[i] : regs_a[i], mregs[i]);
    for (int i = 0; i < DD; i++)
      chk($sformatf("%s.mem%0d", tag, i), sel ? mem_b[i] : mem_a[i], mmem[i]);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 32; i++) rinit[i] = $urandom;
    for (int i = 0; i < DD; i++) minit[i] = $urandom;
    for (int i = 0; i < ID8; i++) imem8[i] = ECALL;
    clear_prog();

    // ALU chain, reset state, x0 preload ignored
    rinit[0] = 32'hDEAD_BEEF;
    imem[0] = enc_i(5, 0, 0, 1, 'h13);
    imem[1] = enc_i(-3, 0, 0, 2, 'h13);
    imem[2] = enc_r(0, 2, 1, 0, 3);
    imem[3] = enc_r(0, 1, 2, 3, 4);
    apply_reset();
    chk("rst.state", {29'd0, st_a}, 32'd0);
    chk("rst.halted", {31'd0, halted_a}, 32'd0);
    chk("rst.pc", pc_a, 32'd0);
    chk("rst.retired", ret_a, 32'd0);
    chk("rst.x0", regs_a[0], 32'd0);
    run_to_halt(cyc);
    chk("alu.x3", regs_a[3], 32'd2);
    chk("alu.x4", regs_a[4], 32'd0);
    chk("alu.retired", ret_a, 32'd4);
    chk("alu.cycles", cyc, 32'd18);
    prog_m = imem; model_run(); check_all("alu", cyc);

    // load/store
    clear_prog();
    rinit[1] = 32'h10;
    imem[0] = enc_s(4, 1, 1);
    imem[1] = enc_i(4, 1, 2, 5, 'h03);
    apply_reset(); run_to_halt(cyc);
    chk("ls.mem5", mem_a[5], 32'h10);
    chk("ls.x5", regs_a[5], 32'h10);
    chk("ls.cycles", cyc, 32'd11);
    prog_m = imem; model_run(); check_all("ls", cyc);

    // branches: not taken, taken backward, signed vs unsigned compare
    clear_prog();
    rinit[7] = 32'hFFFF_FFFF; rinit[8] = 32'd1;
    imem[0] = enc_b(8, 0, 0, 1);
    imem[1] = enc_j(8, 0);
    imem[2] = enc_b(12, 8, 7, 4);
    imem[3] = enc_b(-4, 0, 0, 0);
    imem[5] = enc_b(8, 8, 7, 6);
    apply_reset(); run_to_halt(cyc);
    chk("br.pc", pc_a, 32'h18);
    chk("br.retired", ret_a, 32'd5);
    chk("br.cycles", cyc, 32'd18);
    prog_m = imem; model_run(); check_all("br", cyc);

    // jumps: backward JAL with link, JALR clears bit 0
    clear_prog();
    rinit[6] = 32'h10;
    imem[0] = enc_j(32'h20, 0);
    imem[8] = enc_j(-8, 1);
    imem[6] = enc_i(3, 6, 0, 2, 'h67);
    apply_reset(); run_to_halt(cyc);
    chk("jmp.pc", pc_a, 32'h12);
    chk("jmp.x1", regs_a[1], 32'h24);
    chk("jmp.x2", regs_a[2], 32'h1C);
    prog_m = imem; model_run(); check_all("jmp", cyc);

    // wrap on the 8-word ROM instance, x0 write, LW address wrap
    sel = 1'b1;
    rinit[3] = 32'd0; rinit[12] = 32'd2; minit[1] = 32'hCAFE_F00D;
    imem8[0] = enc_i(1, 3, 0, 3, 'h13);
    imem8[1] = enc_i(7, 0, 0, 0, 'h13);
    imem8[2] = enc_i('h84, 0, 2, 9, 'h03);
    imem8[3] = enc_b(8, 12, 3, 1);
    imem8[5] = enc_j('h2C, 0);
    apply_reset(); run_to_halt(cyc);
    chk("wrap.pc", pc_b, 32'h50);
    chk("wrap.x9", regs_b[9], 32'hCAFE_F00D);
    chk("wrap.x0", regs_b[0], 32'd0);
    chk("wrap.retired", ret_b, 32'd9);
    for (int i = 0; i < ID; i++) prog_m[i] = imem8[i % ID8];
    idepth_m = ID8; model_run(); check_all("wrap", cyc);
    sel = 1'b0; idepth_m = ID;

    // reset while LW sits in MEMORY
    clear_prog();
    rinit[5] = 32'h55; rinit[6] = 32'h66; minit[0] = 32'hABCD_1234; minit[2] = 32'h22;
    imem[0] = enc_i(9, 0, 0, 6, 'h13);
    imem[1] = enc_s(8, 6, 0);
    imem[2] = enc_i(0, 0, 2, 5, 'h03);
    apply_reset();
    for (int i = 0; i < 100 && !(st_a == 3'd3 && ret_a == 32'd2); i++) begin
      @(posedge clk); #1;
    end
    chk("mid.state", {29'd0, st_a}, 32'd3);
    chk("mid.retired", ret_a, 32'd2);
    chk("mid.x6", regs_a[6], 32'd9);
    chk("mid.mem2", mem_a[2], 32'd9);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst2.state", {29'd0, st_a}, 32'd0);
    chk("rst2.pc", pc_a, 32'd0);
    chk("rst2.retired", ret_a, 32'd0);
    chk("rst2.x5", regs_a[5], 32'h55);
    chk("rst2.x6", regs_a[6], 32'h66);
    chk("rst2.mem2", mem_a[2], 32'h22);
    run_to_halt(cyc);
    prog_m = imem; model_run(); check_all("rerun", cyc);

    // illegal opcode halts without retiring, then stays frozen
    clear_prog();
    imem[0] = enc_i(1, 0, 0, 1, 'h13);
    imem[1] = 32'h0000_007F;
    apply_reset(); run_to_halt(cyc);
    chk("ill.retired", ret_a, 32'd1);
    chk("ill.cycles", cyc, 32'd6);
    repeat (5) begin @(posedge clk); #1; end
    chk("ill.frozen_ret", ret_a, 32'd1);
    chk("ill.frozen_pc", pc_a, 32'd4);
    chk("ill.halted", {31'd0, halted_a}, 32'd1);
    prog_m = imem; model_run(); check_all("ill", cyc + 0);

    // random forward-only programs
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 32; i++) rinit[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom;
      for (int i = 0; i < DD; i++) minit[i] = $urandom;
      clear_prog();
      for (int i = 0; i < 20; i++) imem[i] = rand_ins();
      apply_reset(); run_to_halt(cyc);
      prog_m = imem; model_run();
      check_all($sformatf("rnd%0d", p), cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
